key_click_decoder: RTL and testbench
====================================

# key_click_decoder

Classifies debounced key presses into single-click and double-click events and presents them one at a time on a valid/ready event port. Sits directly downstream of the key debounce stage: it consumes that stage's one-cycle-per-press `key_pulse` bus, one bit per key. It feeds the UI control logic, which pops events at its own pace.

## Interface
- `N`, 1: number of keys; equals the debounce stage's `N`.
- `WIN_NUM`, 12000000: double-click window in clk cycles (250 ms at 48 MHz); must be ≥ 2.
- `WIDTH`, 24: window counter width; must satisfy 2^WIDTH > WIN_NUM.
- `IDXW`, 1: width of `evt_key`; must satisfy 2^IDXW ≥ N and IDXW ≥ 1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `key_pulse`  in  N  debounced press pulses, active high, one cycle per press.
- `evt_valid`  out  1  event register holds an event.
- `evt_ready`  in  1  consumer accepts the event this cycle.
- `evt_key`  out  IDXW  index of the key that produced the event.
- `evt_type`  out  1  0 = single click, 1 = double click.
- `evt_ovf`  out  1  one-cycle pulse: an event was dropped.

## Operation
- Each key has an independent FSM with states IDLE and WAIT, a WIDTH-bit window counter `cnt`, and one pending slot (`pend`, `pend_type`).
- IDLE + pulse → WAIT, `cnt` ← 0.
- WAIT + pulse → classify DOUBLE, go to IDLE.
- WAIT, no pulse, `cnt` == WIN_NUM-1 → classify SINGLE, go to IDLE.
- WAIT otherwise → `cnt` ← `cnt`+1. The counter never wraps; its maximum value is WIN_NUM-1.
- Pulse in the same cycle as expiry (`cnt` == WIN_NUM-1): the pulse wins and the FSM classifies DOUBLE.
- A third press after a double starts a new sequence from IDLE.
- Classify sets `pend` and `pend_type` for that key. This is accepted in either of two cases:
  - `pend` is clear.
  - `pend` is being drained into the event register in the same cycle.
- Otherwise the new event is dropped, `pend` keeps its old content, and `evt_ovf` is 1 for the following cycle.
- Arbiter: the event register is loadable when `evt_valid` == 0 or (`evt_valid` & `evt_ready`). When it is loadable, it loads the lowest-index key with `pend` set, and clears that key's `pend`.
- Handshake:
  - A transfer occurs on any cycle with `evt_valid` & `evt_ready`.
  - `evt_key` and `evt_type` stay stable while `evt_valid` is high and `evt_ready` is low.
  - `evt_valid` never drops without a transfer.
  - Back-to-back transfers run at 1 event per cycle.
- Reset (including mid-window or with events pending): all FSMs go to IDLE, `cnt` = 0, all `pend` = 0, `evt_valid` = 0, `evt_key` = 0, `evt_type` = 0, `evt_ovf` = 0.

## Timing
- Double click: the second pulse is high in cycle t. `pend` is set at the edge ending cycle t. `evt_valid` is high from cycle t+2, provided the register is loadable in cycle t+1.
- Single click: the first pulse is high in cycle t and no further pulse follows.
  - WAIT is entered in cycle t+1 with `cnt` = 0.
  - Expiry occurs in cycle t+WIN_NUM.
  - `evt_valid` is high in cycle t+WIN_NUM+2.
- A second pulse is classified DOUBLE if it arrives in any cycle t+1 … t+WIN_NUM.
- `evt_ovf` asserts 1 cycle after the dropped classification and lasts exactly 1 cycle.
- Under a stalled consumer, each key holds at most one pending event. At most N+1 events are buffered in total.

## Structure
- Shared package `key_pkg`:
  - state enum {ST_IDLE, ST_WAIT};
  - event-type constants EVT_SINGLE = 1'b0, EVT_DOUBLE = 1'b1;
  - default WIN_NUM and WIDTH.
- Sub-module `key_click_fsm`, instantiated N times in a generate loop: one key's FSM, counter and pending slot. Its ports are the pulse input, drain input, and the pend/pend_type/ovf outputs.
- The top level contains the fixed-priority arbiter, the event register, and an OR of the per-key overflow outputs to form `evt_ovf`.

## Test plan
Bench setting: N=4, WIN_NUM=8, WIDTH=4, IDXW=2, `evt_ready`=1 unless stated.
- Key 2 pulse at cycle 10, no further pulses → single event with `evt_key`=2, `evt_type`=0, `evt_valid` high exactly in cycle 20.
- Key 0 pulses at cycles 10 and 14 → one double event with `evt_key`=0, `evt_type`=1, `evt_valid` in cycle 16; no single event afterwards.
- Key 1 pulses at cycles 10 and 18 (expiry cycle) → double event only. Pulses at 10 and 19 → single event in cycle 20, then a new window starts.
- `evt_ready`=0; keys 3 and 1 each double-click, both completing in cycle 20 → `evt_valid` from cycle 22 with key 1. Raising `evt_ready` at cycle 30 gives transfers in cycles 30 (key 1) and 31 (key 3).
- `evt_ready`=0; key 0 double-clicks twice (pulses at 10, 12, 14, 16), then key 0 double-clicks again (pulses at 18, 20) → third event dropped, `evt_ovf`=1 in cycle 21 only; the held event is still the first double.
- `rst_n`=0 at cycle 15 with key 2 in WAIT and one event pending → all outputs 0 at cycle 16; no event emitted after reset release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the key click decoder.
// Imported by the per-key FSM and the top-level arbiter.
package key_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } key_state_e;

    localparam logic EVT_SINGLE = 1'b0;
    localparam logic EVT_DOUBLE = 1'b1;

    localparam int WIN_NUM_DEF = 12000000;
    localparam int WIDTH_DEF   = 24;

endpackage

// File: rtl/key_click_decoder_if.sv
// Event port of the click decoder: valid/ready handshake
// plus the one-cycle overflow indication.
interface key_click_decoder_if #(
    parameter int IDXW = 1
) ();

    logic            evt_valid;
    logic            evt_ready;
    logic [IDXW-1:0] evt_key;
    logic            evt_type;
    logic            evt_ovf;

    modport master (
        output evt_valid,
        output evt_key,
        output evt_type,
        output evt_ovf,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_key,
        input  evt_type,
        input  evt_ovf,
        output evt_ready
    );

endinterface

// File: rtl/key_click_fsm.sv
// One key: IDLE/WAIT click classifier, window counter
// and a single pending-event slot with drop detection.
module key_click_fsm
    import key_pkg::*;
#(
    parameter int WIN_NUM = WIN_NUM_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse,
    input  logic drain,
    output logic pend,
    output logic pend_type,
    output logic ovf
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(WIN_NUM - 1);

    key_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             type_q, type_d;
    logic             ovf_q, ovf_d;
    logic             classify;
    logic             cls_type;
    logic             accept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        classify = 1'b0;
        cls_type = EVT_SINGLE;
        unique case (state_q)
            ST_IDLE: begin
                if (pulse) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // a pulse on the expiry cycle still counts as double
                if (pulse) begin
                    classify = 1'b1;
                    cls_type = EVT_DOUBLE;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_MAX) begin
                    classify = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        accept = ~pend_q | drain;
        pend_d = pend_q & ~drain;
        type_d = type_q;
        ovf_d  = classify & ~accept;
        if (classify && accept) begin
            pend_d = 1'b1;
            type_d = cls_type;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            type_q  <= EVT_SINGLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            type_q  <= type_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pend      = pend_q;
    assign pend_type = type_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/key_click_decoder.sv
// Per-key click classifiers feeding a lowest-index-first
// arbiter and a single valid/ready event register.
module key_click_decoder
    import key_pkg::*;
#(
    parameter int N       = 1,
    parameter int WIN_NUM = WIN_NUM_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int IDXW    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key_pulse,
    key_click_decoder_if.master evt
);

    logic [N-1:0]    pend;
    logic [N-1:0]    pend_type;
    logic [N-1:0]    ovf;
    logic [N-1:0]    drain;
    logic [N-1:0]    grant_oh;
    logic [IDXW-1:0] grant_idx;
    logic            grant_type;
    logic            any_pend;
    logic            load;

    logic            valid_q, valid_d;
    logic [IDXW-1:0] key_q, key_d;
    logic            type_q, type_d;

    for (genvar i = 0; i < N; i++) begin : g_key
        key_click_fsm #(
            .WIN_NUM (WIN_NUM),
            .WIDTH   (WIDTH)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .pulse     (key_pulse[i]),
            .drain     (drain[i]),
            .pend      (pend[i]),
            .pend_type (pend_type[i]),
            .ovf       (ovf[i])
        );
    end

    // descending scan so the lowest pending index wins
    always_comb begin
        grant_oh   = '0;
        grant_idx  = '0;
        grant_type = EVT_SINGLE;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_idx   = IDXW'(i);
                grant_type  = pend_type[i];
            end
        end
    end

    assign any_pend = |pend;
    assign load     = ~valid_q | evt.evt_ready;
    assign drain    = {N{load}} & grant_oh;

    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        type_d  = type_q;
        if (load) begin
            valid_d = any_pend;
            if (any_pend) begin
                key_d  = grant_idx;
                type_d = grant_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            key_q   <= '0;
            type_q  <= EVT_SINGLE;
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
            type_q  <= type_d;
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_key   = key_q;
    assign evt.evt_type  = type_q;
    assign evt.evt_ovf   = |ovf;

endmodule

// File: tb/tb_key_click_decoder.sv
// Scenario and randomized checks for key_click_decoder
// with N=4, WIN_NUM=8, WIDTH=4, IDXW=2.
module tb_key_click_decoder;

    localparam int N     = 4;
    localparam int WIN   = 8;
    localparam int WIDTH = 4;
    localparam int IDXW  = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_pulse;
    logic [4:0]   obs;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    key_click_decoder_if #(.IDXW(IDXW)) evt_if ();

    key_click_decoder #(
        .N       (N),
        .WIN_NUM (WIN),
        .WIDTH   (WIDTH),
        .IDXW    (IDXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_pulse (key_pulse),
        .evt       (evt_if)
    );

    // {valid, key[1:0], type, ovf}
    assign obs = {evt_if.evt_valid, evt_if.evt_key,
                  evt_if.evt_type, evt_if.evt_ovf};

    // Reset for two edges; returns at the negedge of cycle 0.
    task automatic start();
        rst_n = 1'b0;
        key_pulse = '0;
        evt_if.evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        evt_if.evt_ready = 1'b1;
        key_pulse = 4'($urandom);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            key_pulse = 4'($urandom);
            total++;
            if (obs !== 5'b0)
                $display("FAIL reset c=%0d: got %b want %b",
                         c, obs, 5'b0);
            else
                passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        logic [4:0] exp;
        start();
        for (int c = 0; c <= 30; c++) begin
            key_pulse = (c == 10) ? 4'b0100 : 4'b0000;
            exp = (c == 20) ? {1'b1, 2'd2, 1'b0, 1'b0} : 5'b0;
            total++;
            if (exp[4] ? obs !== exp
                       : {obs[4], obs[0]} !== {exp[4], exp[0]})
                $display("FAIL single c=%0d: got %b want %b",
                         c, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_double();
        logic [4:0] exp;
        start();
        for (int c = 0; c <= 40; c++) begin
            key_pulse = (c == 10 || c == 14) ? 4'b0001 : 4'b0000;
            exp = (c == 16) ? {1'b1, 2'd0, 1'b1, 1'b0} : 5'b0;
            total++;
            if (exp[4] ? obs !== exp
                       : {obs[4], obs[0]} !== {exp[4], exp[0]})
                $display("FAIL double c=%0d: got %b want %b",
                         c, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_expiry_edge();
        logic [4:0] exp;
        start();
        for (int c = 0; c <= 40; c++) begin
            key_pulse = (c == 10 || c == 18) ? 4'b0010 : 4'b0000;
            exp = (c == 20) ? {1'b1, 2'd1, 1'b1, 1'b0} : 5'b0;
            total++;
            if (exp[4] ? obs !== exp
                       : {obs[4], obs[0]} !== {exp[4], exp[0]})
                $display("FAIL edge_dbl c=%0d: got %b want %b",
                         c, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
        start();
        for (int c = 0; c <= 40; c++) begin
            key_pulse = (c == 10 || c == 19) ? 4'b0010 : 4'b0000;
            exp = (c == 20 || c == 29) ? {1'b1, 2'd1, 1'b0, 1'b0}
                                       : 5'b0;
            total++;
            if (exp[4] ? obs !== exp
                       : {obs[4], obs[0]} !== {exp[4], exp[0]})
                $display("FAIL edge_sgl c=%0d: got %b want %b",
                         c, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_stall_priority();
        logic [4:0] exp;
        start();
        for (int c = 0; c <= 40; c++) begin
            key_pulse = (c == 15 || c == 20) ? 4'b1010 : 4'b0000;
            evt_if.evt_ready = (c >= 30);
            if (c >= 22 && c <= 30)
                exp = {1'b1, 2'd1, 1'b1, 1'b0};
            else if (c == 31)
                exp = {1'b1, 2'd3, 1'b1, 1'b0};
            else
                exp = 5'b0;
            total++;
            if (exp[4] ? obs !== exp
                       : {obs[4], obs[0]} !== {exp[4], exp[0]})
                $display("FAIL stall c=%0d: got %b want %b",
                         c, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] exp;
        start();
        for (int c = 0; c <= 40; c++) begin
            key_pulse = (c >= 10 && c <= 20 && c % 2 == 0)
                        ? 4'b0001 : 4'b0000;
            evt_if.evt_ready = (c >= 30);
            exp = 5'b0;
            if (c >= 14 && c <= 31)
                exp = {1'b1, 2'd0, 1'b1, 1'b0};
            exp[0] = (c == 21);
            total++;
            if (exp[4] ? obs !== exp
                       : {obs[4], obs[0]} !== {exp[4], exp[0]})
                $display("FAIL overflow c=%0d: got %b want %b",
                         c, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        logic [4:0] exp;
        logic       full;
        start();
        for (int c = 0; c <= 40; c++) begin
            key_pulse = '0;
            if (c == 5 || c == 7)  key_pulse[0] = 1'b1;
            if (c == 8 || c == 10) key_pulse[1] = 1'b1;
            if (c == 12)           key_pulse[2] = 1'b1;
            rst_n = (c != 15);
            evt_if.evt_ready = (c >= 16);
            exp = (c >= 9 && c <= 15) ? {1'b1, 2'd0, 1'b1, 1'b0}
                                      : 5'b0;
            full = exp[4] | (c == 16);
            total++;
            if (full ? obs !== exp
                     : {obs[4], obs[0]} !== {exp[4], exp[0]})
                $display("FAIL mid_reset c=%0d: got %b want %b",
                         c, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
    endtask

    // Per-key event order from press timing alone: a press opens
    // a window; a press within WIN cycles is a double, else the
    // window closes WIN cycles after the opening press as a single.
    // Presses per key are spaced >= 5 cycles apart so with ready
    // held high no event can be dropped.
    task automatic test_random();
        int  first_t [N];
        bit  open    [N];
        int  last_p  [N];
        bit  exp_q   [N][$];
        int  left;
        int  k;
        bit  want;
        start();
        for (int i = 0; i < N; i++) begin
            open[i]   = 1'b0;
            first_t[i] = 0;
            last_p[i] = -100;
        end
        for (int c = 0; c < 2040; c++) begin
            key_pulse = '0;
            for (int i = 0; i < N; i++) begin
                if (c < 2000 && c - last_p[i] >= 5
                    && $urandom_range(0, 5) == 0) begin
                    key_pulse[i] = 1'b1;
                    last_p[i] = c;
                end
                if (key_pulse[i]) begin
                    if (open[i]) begin
                        exp_q[i].push_back(1'b1);
                        open[i] = 1'b0;
                    end else begin
                        open[i]    = 1'b1;
                        first_t[i] = c;
                    end
                end else if (open[i] && c == first_t[i] + WIN) begin
                    exp_q[i].push_back(1'b0);
                    open[i] = 1'b0;
                end
            end
            if (evt_if.evt_valid === 1'b1) begin
                k = int'(evt_if.evt_key);
                total++;
                if (exp_q[k].size() == 0) begin
                    $display("FAIL rand_evt c=%0d: got key %0d want none",
                             c, k);
                end else begin
                    want = exp_q[k].pop_front();
                    if (evt_if.evt_type !== want)
                        $display("FAIL rand_type c=%0d key %0d: got %b want %b",
                                 c, k, evt_if.evt_type, want);
                    else
                        passed++;
                end
            end
            total++;
            if (evt_if.evt_ovf !== 1'b0)
                $display("FAIL rand_ovf c=%0d: got %b want 0",
                         c, evt_if.evt_ovf);
            else
                passed++;
            @(negedge clk);
        end
        left = 0;
        for (int i = 0; i < N; i++) left += exp_q[i].size();
        total++;
        if (left !== 0)
            $display("FAIL rand_drain: got %0d left want 0", left);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_expiry_edge();
        test_stall_priority();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
